// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART types and SoC-level constants.
//   UART_RX_FIFO_DEPTH : default depth of the receive buffer FIFO.
//   uart_rx_entry_t    : one received character plus its parity-error flag.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_RX_FIFO_DEPTH = 16;

    typedef struct packed {
        logic       parity_error;
        logic [7:0] data;
    } uart_rx_entry_t;

endpackage : uart_pkg

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Generic single-clock show-ahead FIFO. The head entry is always visible on
// head_o. The caller gates head_o when the FIFO is empty.
//   clk_i, rst_i    : clock, asynchronous active-high reset
//   clear_i         : synchronous clear; wins over a same-cycle push/pop
//   push_i, push_data_i : write request and entry
//   pop_i           : pop request (ignored while empty)
//   head_o          : oldest entry (undefined contents while empty)
//   empty_o, full_o, count_o : occupancy status
//   push_accept_o, pop_accept_o : the push/pop actually took effect this cycle
// A push into a full FIFO is accepted when a pop is accepted in the same cycle.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int  DEPTH   = 16,
    parameter type entry_t = logic [7:0],
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          push_i,
    input  entry_t        push_data_i,
    input  logic          pop_i,
    output entry_t        head_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [CW-1:0] count_o,
    output logic          push_accept_o,
    output logic          pop_accept_o
);

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic            pop_ok;
    logic            push_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a full FIFO can still take a
    // write when it is read at the same time. There is no bypass when empty.
    assign pop_ok        = pop_i && !empty_o;
    assign push_ok       = push_i && (!full_o || pop_ok);
    assign pop_accept_o  = pop_ok && !clear_i;
    assign push_accept_o = push_ok && !clear_i;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately left out of reset. The pointers
    // and count define which entries are valid, and an unreset array maps onto
    // plain RAM or register files.
    always_ff @(posedge clk_i) begin
        if (push_accept_o) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule : sync_fifo

// File: rtl/uart_rx_buffer.sv
// -----------------------------------------------------------------------------
// uart_rx_buffer
// Receive-side buffer behind the UART receiver. Each completed character and
// its parity flag go into a show-ahead FIFO. The block reports level,
// threshold, sticky overrun and character-timeout status.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   flush_i             : synchronous clear of FIFO and timeout state
//   sample_i            : 16x oversampling tick (timeout time base)
//   rx_data_i, rx_done_i, rx_parity_error_i : character strobe from receiver
//   rx_idle_i           : receiver is idle (line quiet)
//   read_i              : pop head entry
//   read_data_o, read_parity_error_o : head entry, 0 when empty
//   empty_o, full_o, count_o : occupancy
//   threshold_i / threshold_irq_o    : level interrupt, threshold 0 disables
//   timeout_ticks_i / timeout_irq_o  : idle-timeout interrupt, 0 disables
//   overrun_o / clear_overrun_i      : sticky dropped-character flag
// -----------------------------------------------------------------------------
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int  DEPTH         = UART_RX_FIFO_DEPTH,
    parameter int  TIMEOUT_WIDTH = 16,
    localparam int CW            = $clog2(DEPTH) + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     sample_i,
    input  logic [7:0]               rx_data_i,
    input  logic                     rx_done_i,
    input  logic                     rx_parity_error_i,
    input  logic                     rx_idle_i,
    input  logic                     read_i,
    output logic [7:0]               read_data_o,
    output logic                     read_parity_error_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [CW-1:0]            count_o,
    input  logic [CW-1:0]            threshold_i,
    output logic                     threshold_irq_o,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_ticks_i,
    output logic                     timeout_irq_o,
    output logic                     overrun_o,
    input  logic                     clear_overrun_i
);

    uart_rx_entry_t           push_entry;
    uart_rx_entry_t           head_entry;
    logic                     push_accept;
    logic                     pop_accept;

    logic                     overrun_q, overrun_d;
    logic [TIMEOUT_WIDTH-1:0] tcnt_q,    tcnt_d;
    logic                     tirq_q,    tirq_d;
    logic                     overrun_set;
    logic                     tcnt_clear;

    assign push_entry = '{parity_error: rx_parity_error_i, data: rx_data_i};

    sync_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (uart_rx_entry_t)
    ) u_fifo (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clear_i       (flush_i),
        .push_i        (rx_done_i),
        .push_data_i   (push_entry),
        .pop_i         (read_i),
        .head_o        (head_entry),
        .empty_o       (empty_o),
        .full_o        (full_o),
        .count_o       (count_o),
        .push_accept_o (push_accept),
        .pop_accept_o  (pop_accept)
    );

    // Head is gated so the bus never sees stale storage contents.
    assign read_data_o         = empty_o ? 8'h00 : head_entry.data;
    assign read_parity_error_o = empty_o ? 1'b0  : head_entry.parity_error;

    assign threshold_irq_o = (threshold_i != '0) && (count_o >= threshold_i);

    // A character is only lost when full and not read in the same cycle.
    // A character dropped by a flush is discarded without flagging overrun.
    assign overrun_set = rx_done_i && full_o && !read_i && !flush_i;

    // Any FIFO activity or an empty FIFO restarts the idle measurement.
    assign tcnt_clear = flush_i || push_accept || pop_accept || empty_o;

    always_comb begin
        overrun_d = overrun_q;
        tcnt_d    = tcnt_q;
        tirq_d    = tirq_q;

        // Set wins over a same-cycle clear.
        if (overrun_set)          overrun_d = 1'b1;
        else if (clear_overrun_i) overrun_d = 1'b0;

        if (tcnt_clear) begin
            tcnt_d = '0;
            tirq_d = 1'b0;
        end else begin
            if (sample_i && rx_idle_i && (tcnt_q < timeout_ticks_i))
                tcnt_d = tcnt_q + TIMEOUT_WIDTH'(1);
            // Sticky until the counter is cleared, even if the limit changes.
            if ((timeout_ticks_i != '0) && (tcnt_d == timeout_ticks_i))
                tirq_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overrun_q <= 1'b0;
            tcnt_q    <= '0;
            tirq_q    <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
            tcnt_q    <= tcnt_d;
            tirq_q    <= tirq_d;
        end
    end

    assign overrun_o     = overrun_q;
    assign timeout_irq_o = tirq_q;

endmodule : uart_rx_buffer
